network_sequencer: RTL and testbench

//  Parametrised forward-pass sequencer for an N-layer cached dilated causal conv network.
//  One accepted sample strobe produces one pass:

---
 rtl/network_seq_pkg.sv | 27 ++
 rtl/layer_watchdog.sv | 47 ++++
 rtl/network_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_network_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/network_seq_pkg.sv
// rtl/network_seq_pkg.sv - shared types and helpers for the network sequencer
//
// Purpose: pass-sequencer state encoding, perf counter width and a
//          saturating increment helper used by the status counters.
// Ports:   none (package).

package network_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      ADVANCE = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int PERF_W = 16;

   // Increment that sticks at the all-ones value of a 'width'-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_v) ? max_v : (value + 32'd1);
   endfunction

endpackage

// File: rtl/layer_watchdog.sv
// rtl/layer_watchdog.sv - per-layer conv_done wait watchdog
//
// Purpose: counts cycles spent waiting for one layer's conv_done and flags
//          expiry on the MAX_WAIT-th waiting cycle.
// Ports:
//   clk      in  clock
//   rst      in  synchronous reset, active-high
//   clear    in  restart the count (issued when a layer is started)
//   enable   in  a waiting cycle is in progress
//   expired  out this waiting cycle is the last one allowed

module layer_watchdog #(
   parameter int MAX_WAIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   logic [CW-1:0] wait_cnt_q;
   logic [CW-1:0] wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clear) begin
         wait_cnt_d = '0;
      end else if (enable) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Count 0 is the first waiting cycle, so MAX_WAIT-1 is the last one.
   assign expired = enable && (wait_cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/network_sequencer.sv
// rtl/network_sequencer.sv - forward-pass sequencer for an N-layer cached conv network
//
// Purpose: one accepted sample strobe runs one pass: advance input shift
//          buffer, then per layer start conv / wait done / advance cache,
//          then latch the final layer output. Includes a per-layer done
//          watchdog, saturating overrun accounting and optional pass timing.
// Build option: NETWORK_SEQ_PERF_EN enables pass_cycles/max_pass_cycles;
//          without it both ports are tied to zero.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sample_strobe     new sample pulse
//   clr_status        clears timeout, overrun_count, max_pass_cycles
//   lsb_advance       pulse: clock input shift buffers
//   conv_start        one-hot pulse: start conv[layer]
//   conv_done         conv[i] output valid (level)
//   cache_advance     one-hot pulse: capture conv[layer] into cache[layer]
//   last_out          final conv packed output (element 0 in MSBs)
//   sample_out        registered network output
//   out_valid         pulse: sample_out updated
//   busy              pass in progress
//   timeout           sticky layer wait timeout
//   overrun_count     saturating count of dropped strobes
//   pass_cycles       length of last completed pass
//   max_pass_cycles   longest pass since reset/clear

module network_sequencer
   import network_seq_pkg::*;
#(
   parameter int W        = 16,
   parameter int OUT_D    = 4,
   parameter int N_LAYERS = 3,
   parameter int MAX_WAIT = 1024,
   parameter int OVR_W    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_strobe,
   input  logic                   clr_status,
   output logic                   lsb_advance,
   output logic [N_LAYERS-1:0]    conv_start,
   input  logic [N_LAYERS-1:0]    conv_done,
   output logic [N_LAYERS-2:0]    cache_advance,
   input  logic [OUT_D*W-1:0]     last_out,
   output logic [OUT_D*W-1:0]     sample_out,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   timeout,
   output logic [OVR_W-1:0]       overrun_count,
   output logic [PERF_W-1:0]      pass_cycles,
   output logic [PERF_W-1:0]      max_pass_cycles
);

   localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
   localparam int CW = N_LAYERS - 1;

   state_t               state_q, state_d;
   logic [LW-1:0]        layer_q, layer_d;
   logic [OUT_D*W-1:0]   sample_out_q, sample_out_d;
   logic                 timeout_q, timeout_d;
   logic [OVR_W-1:0]     overrun_q, overrun_d;

   logic wd_clear;
   logic wd_enable;
   logic wd_expired;
   logic timeout_evt;
   logic accept;
   logic drop;

   // Watchdog controls depend on state only, keeping them out of the
   // next-state process that consumes wd_expired.
   assign wd_clear  = (state_q == START);
   assign wd_enable = (state_q == WAIT);

   layer_watchdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   assign accept = sample_strobe && ((state_q == IDLE) || (state_q == DONE));
   // WAIT includes the abort cycle, so a strobe coinciding with a timeout
   // is dropped and counted rather than starting a new pass.
   assign drop   = sample_strobe && ((state_q == SHIFT) || (state_q == START) ||
                                     (state_q == WAIT)  || (state_q == ADVANCE));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         layer_q      <= '0;
         sample_out_q <= '0;
         timeout_q    <= 1'b0;
         overrun_q    <= '0;
      end else begin
         state_q      <= state_d;
         layer_q      <= layer_d;
         sample_out_q <= sample_out_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d      = state_q;
      layer_d      = layer_q;
      sample_out_d = sample_out_q;
      timeout_evt  = 1'b0;

      case (state_q)
         IDLE: begin
            if (sample_strobe) state_d = SHIFT;
         end
         SHIFT: begin
            layer_d = '0;
            state_d = START;
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Only the active layer's done bit matters, and only here.
            if (conv_done[layer_q]) begin
               if (layer_q == LW'(N_LAYERS - 1)) begin
                  sample_out_d = last_out;
                  state_d      = DONE;
               end else begin
                  state_d = ADVANCE;
               end
            end else if (wd_expired) begin
               timeout_evt = 1'b1;
               state_d     = IDLE;
            end
         end
         ADVANCE: begin
            layer_d = layer_q + LW'(1);
            state_d = START;
         end
         DONE: begin
            state_d = sample_strobe ? SHIFT : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A same-cycle event beats clr_status.
      if (timeout_evt) begin
         timeout_d = 1'b1;
      end else if (clr_status) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end

      if (drop) begin
         overrun_d = clr_status ? OVR_W'(1) : OVR_W'(sat_inc(32'(overrun_q), OVR_W));
      end else if (clr_status) begin
         overrun_d = '0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Output decode of the registered state
   always_comb begin
      lsb_advance   = (state_q == SHIFT);
      conv_start    = (state_q == START)   ? (N_LAYERS'(1) << layer_q) : '0;
      cache_advance = (state_q == ADVANCE) ? (CW'(1) << layer_q)       : '0;
      out_valid     = (state_q == DONE);
      busy          = (state_q != IDLE) && (state_q != DONE);
   end

   assign sample_out    = sample_out_q;
   assign timeout       = timeout_q;
   assign overrun_count = overrun_q;

`ifdef NETWORK_SEQ_PERF_EN
   logic [PERF_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [PERF_W-1:0] pass_cycles_q, pass_cycles_d;
   logic [PERF_W-1:0] max_pass_q, max_pass_d;

   always_comb begin
      pass_cnt_d    = pass_cnt_q;
      pass_cycles_d = pass_cycles_q;
      max_pass_d    = max_pass_q;

      // The count loaded on acceptance covers the strobe cycle and the
      // SHIFT cycle, so in DONE it holds the full pass length.
      if (accept) begin
         pass_cnt_d = PERF_W'(2);
      end else if (busy) begin
         pass_cnt_d = pass_cnt_q + PERF_W'(1);
      end

      if (state_q == DONE) begin
         pass_cycles_d = pass_cnt_q;
         if (clr_status || (pass_cnt_q > max_pass_q)) begin
            max_pass_d = pass_cnt_q;
         end
      end else if (clr_status) begin
         max_pass_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt_q    <= '0;
         pass_cycles_q <= '0;
         max_pass_q    <= '0;
      end else begin
         pass_cnt_q    <= pass_cnt_d;
         pass_cycles_q <= pass_cycles_d;
         max_pass_q    <= max_pass_d;
      end
   end

   assign pass_cycles     = pass_cycles_q;
   assign max_pass_cycles = max_pass_q;
`else
   assign pass_cycles     = '0;
   assign max_pass_cycles = '0;
`endif

endmodule

// File: tb/tb_network_sequencer.sv
// tb/tb_network_sequencer.sv - directed self-checking bench for network_sequencer

module tb_network_sequencer;

   localparam int W     = 16;
   localparam int OUT_D = 4;
   localparam int N     = 3;
   localparam int MW    = 8;
   localparam int OVR_W = 2;

   localparam logic [63:0] OUT_A = 64'h0001_0002_0003_0004;
   localparam logic [63:0] OUT_B = 64'hdead_beef_0000_1111;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_strobe;
   logic              clr_status;
   logic              lsb_advance;
   logic [N-1:0]      conv_start;
   logic [N-1:0]      conv_done;
   logic [N-2:0]      cache_advance;
   logic [63:0]       last_out;
   logic [63:0]       sample_out;
   logic              out_valid;
   logic              busy;
   logic              timeout;
   logic [OVR_W-1:0]  overrun_count;
   logic [15:0]       pass_cycles;
   logic [15:0]       max_pass_cycles;

   network_sequencer #(
      .W(W), .OUT_D(OUT_D), .N_LAYERS(N), .MAX_WAIT(MW), .OVR_W(OVR_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sample_strobe   (sample_strobe),
      .clr_status      (clr_status),
      .lsb_advance     (lsb_advance),
      .conv_start      (conv_start),
      .conv_done       (conv_done),
      .cache_advance   (cache_advance),
      .last_out        (last_out),
      .sample_out      (sample_out),
      .out_valid       (out_valid),
      .busy            (busy),
      .timeout         (timeout),
      .overrun_count   (overrun_count),
      .pass_cycles     (pass_cycles),
      .max_pass_cycles (max_pass_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int valid_q[$];
   int lsb_q[$];
   int idle_at;
   bit cadv1_seen;

   typedef struct {
      logic         strobe;
      logic [N-1:0] done;
      logic [7:0]   exp_outs;
      logic [63:0]  exp_sample;
   } vec_t;

   vec_t vec[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mk(input logic l, input logic [2:0] s, input logic [1:0] c,
                                     input logic v, input logic b);
      return {l, s, c, v, b};
   endfunction

   function automatic logic [7:0] outs();
      return {lsb_advance, conv_start, cache_advance, out_valid, busy};
   endfunction

   function automatic logic [63:0] qget(input int q[$], input int idx);
      return (idx < q.size()) ? 64'(q[idx]) : 64'hFFFF_FFFF;
   endfunction

   // Runs ncyc cycles from a cycle boundary; bit c of smask/cmask drives
   // sample_strobe/clr_status in relative cycle c. Records event cycles.
   task automatic run(input int ncyc, input logic [63:0] smask, input logic [63:0] cmask,
                      input logic [N-1:0] done_v);
      valid_q.delete();
      lsb_q.delete();
      idle_at    = -1;
      cadv1_seen = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         sample_strobe = smask[c];
         clr_status    = cmask[c];
         conv_done     = done_v;
         if (out_valid)        valid_q.push_back(c);
         if (lsb_advance)      lsb_q.push_back(c);
         if (cache_advance[1]) cadv1_seen = 1'b1;
         if (c > 0 && !busy && idle_at < 0) idle_at = c;
         @(posedge clk);
         #1;
      end
      sample_strobe = 1'b0;
      clr_status    = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      sample_strobe = 1'b0;
      clr_status    = 1'b0;
      conv_done     = '0;
      last_out      = OUT_A;

      // Nominal pass, one row per cycle; done is held high from START on
      // so the START-cycle done must be ignored.
      vec[0]  = '{1'b1, 3'b000, mk(0, 3'b000, 2'b00, 0, 0), 64'h0};
      vec[1]  = '{1'b0, 3'b000, mk(1, 3'b000, 2'b00, 0, 1), 64'h0};
      vec[2]  = '{1'b0, 3'b111, mk(0, 3'b001, 2'b00, 0, 1), 64'h0};
      vec[3]  = '{1'b0, 3'b111, mk(0, 3'b000, 2'b00, 0, 1), 64'h0};
      vec[4]  = '{1'b0, 3'b111, mk(0, 3'b000, 2'b01, 0, 1), 64'h0};
      vec[5]  = '{1'b0, 3'b111, mk(0, 3'b010, 2'b00, 0, 1), 64'h0};
      vec[6]  = '{1'b0, 3'b111, mk(0, 3'b000, 2'b00, 0, 1), 64'h0};
      vec[7]  = '{1'b0, 3'b111, mk(0, 3'b000, 2'b10, 0, 1), 64'h0};
      vec[8]  = '{1'b0, 3'b111, mk(0, 3'b100, 2'b00, 0, 1), 64'h0};
      vec[9]  = '{1'b0, 3'b111, mk(0, 3'b000, 2'b00, 0, 1), 64'h0};
      vec[10] = '{1'b0, 3'b000, mk(0, 3'b000, 2'b00, 1, 0), OUT_A};
      vec[11] = '{1'b0, 3'b000, mk(0, 3'b000, 2'b00, 0, 0), OUT_A};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", 64'(outs()), 64'h0);
      chk("rst_sample", sample_out, 64'h0);
      chk("rst_status", 64'({timeout, overrun_count}), 64'h0);
      chk("rst_perf", 64'({pass_cycles, max_pass_cycles}), 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         sample_strobe = vec[i].strobe;
         conv_done     = vec[i].done;
         chk($sformatf("nom_outs_c%0d", i), 64'(outs()), 64'(vec[i].exp_outs));
         chk($sformatf("nom_sample_c%0d", i), sample_out, vec[i].exp_sample);
         @(posedge clk);
         #1;
      end
      sample_strobe = 1'b0;
`ifdef NETWORK_SEQ_PERF_EN
      chk("perf_pass_nom", 64'(pass_cycles), 64'd11);
      chk("perf_max_nom", 64'(max_pass_cycles), 64'd11);
`else
      chk("perf_tied_pass", 64'(pass_cycles), 64'd0);
      chk("perf_tied_max", 64'(max_pass_cycles), 64'd0);
`endif

      // Layer 1 never completes: START1 at c5, WAIT c6..c13, IDLE at c14.
      // The strobe at c13 lands on the abort cycle and is dropped.
      last_out = OUT_B;
      run(20, (64'd1 | (64'd1 << 13)), 64'd0, 3'b101);
      chk("to_idle_cycle", 64'(idle_at), 64'd14);
      chk("to_no_valid", 64'(valid_q.size()), 64'd0);
      chk("to_no_cadv1", 64'(cadv1_seen), 64'd0);
      chk("to_sticky", 64'(timeout), 64'd1);
      chk("to_abort_drop", 64'(overrun_count), 64'd1);
      chk("to_sample_held", sample_out, OUT_A);
      chk("to_one_lsb", 64'(lsb_q.size()), 64'd1);
      last_out = OUT_A;

      run(1, 64'd0, 64'd1, 3'b000);
      chk("clr_timeout", 64'(timeout), 64'd0);
      chk("clr_overrun", 64'(overrun_count), 64'd0);

      // Three dropped strobes during one pass.
      run(14, 64'b101_0101, 64'd0, 3'b111);
      chk("ovr3_count", 64'(overrun_count), 64'd3);
      chk("ovr3_one_valid", 64'(valid_q.size()), 64'd1);
      chk("ovr3_valid_cyc", qget(valid_q, 0), 64'd10);

      // Clear on the accepted strobe, then five drops saturate at 3.
      run(14, 64'h3F, 64'd1, 3'b111);
      chk("ovr_sat", 64'(overrun_count), 64'd3);

      // Clear coincides with a dropped strobe: the new drop is counted.
      run(14, 64'b1101, 64'b1000, 3'b111);
      chk("clr_vs_drop", 64'(overrun_count), 64'd1);

      // Strobe in DONE starts the next pass with zero gap.
      run(24, (64'd1 | (64'd1 << 10)), 64'd0, 3'b111);
      chk("b2b_lsb0", qget(lsb_q, 0), 64'd1);
      chk("b2b_lsb1", qget(lsb_q, 1), 64'd11);
      chk("b2b_valid0", qget(valid_q, 0), 64'd10);
      chk("b2b_valid1", qget(valid_q, 1), 64'd20);
      chk("b2b_no_drop", 64'(overrun_count), 64'd1);

      // Slow pass: layer 0 sees done one cycle late (pass length 12).
      run(4, 64'd1, 64'd0, 3'b000);
      run(16, 64'd0, 64'd0, 3'b111);
      chk("slow_valid_cyc", qget(valid_q, 0), 64'd7);
      run(14, 64'd1, 64'd0, 3'b111);
`ifdef NETWORK_SEQ_PERF_EN
      chk("perf_pass_fast", 64'(pass_cycles), 64'd11);
      chk("perf_max_slow", 64'(max_pass_cycles), 64'd12);
`else
      chk("perf_tied_after", 64'({pass_cycles, max_pass_cycles}), 64'd0);
`endif

      // Reset in WAIT of layer 1 (c6), then an idle stretch and a clean pass.
      run(6, 64'd1, 64'd0, 3'b001);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_outs", 64'(outs()), 64'h0);
      chk("mid_rst_sample", sample_out, 64'h0);
      chk("mid_rst_status", 64'({timeout, overrun_count}), 64'h0);
      run(8, 64'd0, 64'd0, 3'b111);
      chk("mid_rst_quiet", 64'(lsb_q.size() + valid_q.size()), 64'd0);
      run(12, 64'd1, 64'd0, 3'b111);
      chk("post_rst_valid", qget(valid_q, 0), 64'd10);
      chk("post_rst_sample", sample_out, OUT_A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
